// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register and load formatter: pairs latched write-back control
// with next-cycle memory read data, extends sub-word loads, counts retired instructions.
module mem_wb_latch #(
  parameter int NB_DATA     = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int NB_PC       = 32,
  parameter int NB_CNT      = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NB_DATA-1:0]     i_mem_data,
  input  logic [NB_DATA-1:0]     i_alu_result,
  input  logic [NB_PC-1:0]       i_pc,
  input  logic [NB_REG_ADDR-1:0] i_reg_dst,
  input  logic                   i_reg_write,
  input  logic                   i_mem_to_reg,
  input  logic                   i_link,
  input  logic [1:0]             i_read_enable,
  input  logic                   i_signed,
  input  logic                   i_halt,
  input  logic                   i_valid,
  input  logic                   i_stall,
  input  logic                   i_flush,
  output logic [NB_DATA-1:0]     o_wb_data,
  output logic [NB_REG_ADDR-1:0] o_wb_reg,
  output logic                   o_reg_write,
  output logic                   o_halt,
  output logic [NB_CNT-1:0]      o_retired
);

  localparam logic [1:0] READ_DISABLE  = 2'b00;
  localparam logic [1:0] READ_BYTE     = 2'b01;
  localparam logic [1:0] READ_HALFWORD = 2'b10;
  localparam logic [1:0] READ_WORD     = 2'b11;

  function automatic logic [NB_DATA-1:0] extend_load(
    input logic [NB_DATA-1:0] raw,
    input logic [1:0]         code,
    input logic               sgn
  );
    logic [NB_DATA-1:0] res;
    res = '0;
    case (code)
      READ_BYTE:     res = {{(NB_DATA-8){sgn & raw[7]}}, raw[7:0]};
      READ_HALFWORD: res = {{(NB_DATA-16){sgn & raw[15]}}, raw[15:0]};
      READ_WORD:     res = raw;
      READ_DISABLE:  res = '0;
      default:       res = '0;
    endcase
    return res;
  endfunction

  logic                   valid_q, valid_d;
  logic                   reg_write_q, reg_write_d;
  logic                   mem_to_reg_q, mem_to_reg_d;
  logic                   link_q, link_d;
  logic                   halt_q, halt_d;
  logic                   signed_q, signed_d;
  logic [1:0]             read_en_q, read_en_d;
  logic [NB_REG_ADDR-1:0] reg_dst_q, reg_dst_d;
  logic [NB_DATA-1:0]     alu_q, alu_d;
  logic [NB_PC-1:0]       pc_q, pc_d;
  logic [NB_DATA-1:0]     hold_q, hold_d;
  logic                   hold_valid_q, hold_valid_d;
  logic [NB_CNT-1:0]      retired_q, retired_d;

  // Next state: flush beats stall beats a normal latch.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    link_d       = link_q;
    halt_d       = halt_q;
    signed_d     = signed_q;
    read_en_d    = read_en_q;
    reg_dst_d    = reg_dst_q;
    alu_d        = alu_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    retired_d    = retired_q;
    if (i_flush) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      link_d       = 1'b0;
      halt_d       = 1'b0;
      hold_valid_d = 1'b0;
    end else if (i_stall) begin
      // The memory only drives the load result for one cycle; capture it once.
      if (!hold_valid_q && valid_q && mem_to_reg_q) begin
        hold_d       = i_mem_data;
        hold_valid_d = 1'b1;
      end
    end else begin
      valid_d      = i_valid;
      reg_write_d  = i_reg_write;
      mem_to_reg_d = i_mem_to_reg;
      link_d       = i_link;
      halt_d       = i_halt;
      signed_d     = i_signed;
      read_en_d    = i_read_enable;
      reg_dst_d    = i_reg_dst;
      alu_d        = i_alu_result;
      pc_d         = i_pc;
      hold_valid_d = 1'b0;
      if (i_valid) retired_d = retired_q + NB_CNT'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      link_q       <= 1'b0;
      halt_q       <= 1'b0;
      signed_q     <= 1'b0;
      read_en_q    <= READ_DISABLE;
      reg_dst_q    <= '0;
      alu_q        <= '0;
      pc_q         <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      retired_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      link_q       <= link_d;
      halt_q       <= halt_d;
      signed_q     <= signed_d;
      read_en_q    <= read_en_d;
      reg_dst_q    <= reg_dst_d;
      alu_q        <= alu_d;
      pc_q         <= pc_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      retired_q    <= retired_d;
    end
  end

  // Write-back stage: only i_mem_data may reach the outputs combinationally.
  logic [NB_DATA-1:0] load_raw;
  logic [NB_DATA-1:0] load_ext;

  always_comb begin
    load_raw = hold_valid_q ? hold_q : i_mem_data;
    load_ext = extend_load(load_raw, read_en_q, signed_q);
    if (link_q)            o_wb_data = NB_DATA'(pc_q);
    else if (mem_to_reg_q) o_wb_data = load_ext;
    else                   o_wb_data = alu_q;
  end

  assign o_wb_reg    = reg_dst_q;
  assign o_reg_write = valid_q & reg_write_q & (reg_dst_q != '0);
  assign o_halt      = valid_q & halt_q;
  assign o_retired   = retired_q;

endmodule

// File: tb/tb_mem_wb_latch.sv
// Scoreboard bench for mem_wb_latch: stimulus queues hand-computed write-back
// results, a negedge monitor pops and compares them in the cycle they are due.
module tb_mem_wb_latch;

  localparam logic [1:0] RD_DIS  = 2'b00;
  localparam logic [1:0] RD_BYTE = 2'b01;
  localparam logic [1:0] RD_HALF = 2'b10;
  localparam logic [1:0] RD_WORD = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_data, alu_result, pc;
  logic [4:0]  reg_dst;
  logic        reg_write, mem_to_reg, link, sgn, halt, valid, stall, flush;
  logic [1:0]  read_enable;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_we, wb_halt;
  logic [3:0]  retired;

  mem_wb_latch #(.NB_DATA(32), .NB_REG_ADDR(5), .NB_PC(32), .NB_CNT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_data(mem_data), .i_alu_result(alu_result),
    .i_pc(pc), .i_reg_dst(reg_dst), .i_reg_write(reg_write), .i_mem_to_reg(mem_to_reg),
    .i_link(link), .i_read_enable(read_enable), .i_signed(sgn), .i_halt(halt),
    .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .o_wb_data(wb_data), .o_wb_reg(wb_reg), .o_reg_write(wb_we), .o_halt(wb_halt),
    .o_retired(retired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       nm;
    logic [31:0] d;
    logic [4:0]  r;
    logic        we;
    logic        h;
    logic [3:0]  ret;
    logic        chk_d;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [3:0] ret = 4'd0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      if (q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expected in cycle %0d, never sampled (now %0d)", q[0].nm, q[0].cyc, cyc);
        void'(q.pop_front());
      end else if (q[0].cyc == cyc) begin
        checks++;
        if ((q[0].chk_d && (wb_data !== q[0].d || wb_reg !== q[0].r)) ||
            wb_we !== q[0].we || wb_halt !== q[0].h || retired !== q[0].ret) begin
          errors++;
          $display("FAIL %s: got data=%h reg=%0d we=%b halt=%b ret=%0d, required data=%h reg=%0d we=%b halt=%b ret=%0d",
                   q[0].nm, wb_data, wb_reg, wb_we, wb_halt, retired,
                   q[0].d, q[0].r, q[0].we, q[0].h, q[0].ret);
        end
        void'(q.pop_front());
      end
    end
  end

  task automatic drive(input logic v, we, m2r, lnk, hlt, sg, input logic [1:0] re,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] p);
    valid = v; reg_write = we; mem_to_reg = m2r; link = lnk; halt = hlt; sgn = sg;
    read_enable = re; reg_dst = rd; alu_result = alu; pc = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wb(input string nm, input logic [31:0] d, input logic [4:0] r,
                           input logic we, input logic h, input logic chk_d);
    exp_t e;
    e.cyc = cyc; e.nm = nm; e.d = d; e.r = r; e.we = we; e.h = h; e.ret = ret; e.chk_d = chk_d;
    q.push_back(e);
  endtask

  // One back-to-back instruction: control now, memory data after the latching edge.
  task automatic run(input string nm, input logic v, we, m2r, lnk, hlt, sg, input logic [1:0] re,
                     input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] p,
                     input logic [31:0] mem, input logic [31:0] ed, input logic ewe, input logic eh);
    drive(v, we, m2r, lnk, hlt, sg, re, rd, alu, p);
    tick();
    mem_data = mem;
    if (v) ret = ret + 4'd1;
    expect_wb(nm, ed, rd, ewe, eh, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; mem_data = '0;
    drive(0, 0, 0, 0, 0, 0, RD_DIS, 5'd0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    expect_wb("reset_state", 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    rst_n = 1'b1;

    //   name        v we m2r lk ht sg re       rd     alu           pc            mem            expected      we ht
    run("lb_signed",  1, 1, 1, 0, 0, 1, RD_BYTE, 5'd3,  32'h0,        32'h0,        32'h000000F0, 32'hFFFFFFF0, 1, 0);
    run("lbu",        1, 1, 1, 0, 0, 0, RD_BYTE, 5'd3,  32'h0,        32'h0,        32'h000000F0, 32'h000000F0, 1, 0);
    run("lh_signed",  1, 1, 1, 0, 0, 1, RD_HALF, 5'd4,  32'h0,        32'h0,        32'h00008001, 32'hFFFF8001, 1, 0);
    run("lhu",        1, 1, 1, 0, 0, 0, RD_HALF, 5'd4,  32'h0,        32'h0,        32'h00008001, 32'h00008001, 1, 0);
    run("lw",         1, 1, 1, 0, 0, 1, RD_WORD, 5'd8,  32'h0,        32'h0,        32'h80000000, 32'h80000000, 1, 0);
    run("lb_hi_bits", 1, 1, 1, 0, 0, 1, RD_BYTE, 5'd2,  32'h0,        32'h0,        32'hABCDEF7F, 32'h0000007F, 1, 0);
    run("read_dis",   1, 1, 1, 0, 0, 0, RD_DIS,  5'd2,  32'h0,        32'h0,        32'hFFFFFFFF, 32'h00000000, 1, 0);
    run("add_to_r0",  1, 1, 0, 0, 0, 0, RD_DIS,  5'd0,  32'h00001234, 32'h0,        32'h0,        32'h00001234, 0, 0);
    run("add",        1, 1, 0, 0, 0, 0, RD_DIS,  5'd7,  32'h0000CAFE, 32'h0,        32'h5555AAAA, 32'h0000CAFE, 1, 0);
    run("jal",        1, 1, 0, 1, 0, 0, RD_DIS,  5'd31, 32'h00000777, 32'h00000048, 32'h0,        32'h00000048, 1, 0);
    run("invalid",    0, 1, 0, 0, 0, 0, RD_DIS,  5'd6,  32'h00000066, 32'h0,        32'h0,        32'h00000066, 0, 0);
    run("halt",       1, 0, 0, 0, 1, 0, RD_DIS,  5'd0,  32'h0,        32'h0,        32'h0,        32'h00000000, 0, 1);

    // Load held across three stall edges while the memory output goes to zero.
    drive(1, 1, 1, 0, 0, 0, RD_WORD, 5'd5, 32'h0, 32'h0);
    tick();
    mem_data = 32'h12345678;
    ret = ret + 4'd1;
    expect_wb("lw_hold0", 32'h12345678, 5'd5, 1'b1, 1'b0, 1'b1);
    drive(1, 1, 0, 0, 0, 0, RD_DIS, 5'd9, 32'h00000099, 32'h0);
    stall = 1'b1;
    tick();
    mem_data = 32'h0;
    expect_wb("lw_hold1", 32'h12345678, 5'd5, 1'b1, 1'b0, 1'b1);
    tick();
    expect_wb("lw_hold2", 32'h12345678, 5'd5, 1'b1, 1'b0, 1'b1);
    tick();
    expect_wb("lw_hold3", 32'h12345678, 5'd5, 1'b1, 1'b0, 1'b1);
    stall = 1'b0;
    tick();
    ret = ret + 4'd1;
    expect_wb("after_stall", 32'h00000099, 5'd9, 1'b1, 1'b0, 1'b1);

    // Flush wins over stall; flushed HALT never reaches write-back.
    drive(1, 1, 0, 0, 0, 0, RD_DIS, 5'd4, 32'h00000044, 32'h0);
    stall = 1'b1; flush = 1'b1;
    tick();
    expect_wb("flush_stall", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    stall = 1'b0;
    drive(1, 0, 0, 0, 1, 0, RD_DIS, 5'd0, 32'h0, 32'h0);
    tick();
    expect_wb("flush_halt", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    flush = 1'b0;
    run("post_flush", 1, 1, 0, 0, 0, 0, RD_DIS, 5'd12, 32'h0000ABCD, 32'h0, 32'h0, 32'h0000ABCD, 1, 0);

    // Asynchronous reset in the middle of a stalled load.
    run("lw_pre_rst", 1, 1, 1, 0, 0, 0, RD_WORD, 5'd6, 32'h0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0);
    drive(0, 0, 0, 0, 0, 0, RD_DIS, 5'd0, 32'h0, 32'h0);
    stall = 1'b1;
    tick();
    mem_data = 32'h0;
    expect_wb("lw_stalled", 32'hDEADBEEF, 5'd6, 1'b1, 1'b0, 1'b1);
    tick();
    #2;
    rst_n = 1'b0;
    ret = 4'd0;
    expect_wb("async_reset", 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    rst_n = 1'b1;
    stall = 1'b0;

    // Sixteen valid latches wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) begin
      run($sformatf("wrap_%0d", i), 1, 1, 0, 0, 0, 0, RD_DIS, 5'd1, 32'(i + 100), 32'h0, 32'h0,
          32'(i + 100), 1, 0);
    end
    drive(0, 0, 0, 0, 0, 0, RD_DIS, 5'd0, 32'h0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
